echo_energy_ctrl: RTL
=====================

Name: echo_energy_ctrl

Overview:
- Sequences the sliding-window sum-of-squares datapath for one ultrasonic receive capture.
- Arms on a start pulse and gates ADC sample strobes into the datapath as its enable. The datapath has no reset, so the block first waits until the window is fully flushed with post-arm samples.
- Then compares the 24-bit window energy against a threshold with N-consecutive confirmation, and reports the echo arrival sample index or a timeout.

Parameters:
- WINDOW, 260, window depth of the energy datapath in samples.
- CONFIRM, 4, consecutive above-threshold compares required to declare detection (1..15).
- CNT_W, 16, sample counter width.

Ports:
- SYS_CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle arm request; honoured only in IDLE or DONE.
- abort  in  1  return to IDLE; highest priority.
- adcValid  in  1  new ADC sample present this cycle.
- energyIn  in  24  window energy from the datapath; updated on each sumEnable edge.
- threshold  in  24  detection threshold, unsigned; sampled continuously.
- maxSamples  in  CNT_W  capture length limit in samples.
- sumEnable  out  1  enable to the datapath shift register and accumulator.
- busy  out  1  high in FILL or RUN.
- windowFull  out  1  high in RUN.
- detect  out  1  one-cycle pulse on detection.
- timeout  out  1  one-cycle pulse on capture expiry without detection.
- done  out  1  high in DONE.
- detectIndex  out  CNT_W  sampleCount at the confirming compare; held until next start.

Behaviour:
- Reset (RST_N=0 at edge): state=IDLE; sampleCount=0; runCnt=0; cmpPending=0. All registered outputs are 0, including detectIndex.
- States:
  - IDLE -> FILL on start.
  - FILL -> RUN on the enable that makes sampleCount == WINDOW+1.
  - RUN -> DONE on detect or timeout. FILL -> DONE on timeout.
  - DONE -> FILL on start.
  - Any state -> IDLE on abort. Abort beats start in the same cycle.
- Entering FILL clears sampleCount, runCnt, detectIndex and cmpPending.
- sumEnable = adcValid & (state is FILL or RUN) & ~abort & RST_N. This is combinational, so the datapath sees the enable in the same cycle.
- On each sumEnable: sampleCount increments, saturating at 2^CNT_W-1, and cmpPending is set for the next cycle.
- Compare cycle (cmpPending=1). Here energyIn is the value registered at the preceding enable edge and k = sampleCount.
  - If k >= WINDOW+1: runCnt = (energyIn > threshold) ? runCnt+1 : 0. Strictly greater; equal counts as below.
  - If k <= WINDOW: runCnt stays 0. Energy is ignored while filling.
  - If runCnt+1 reaches CONFIRM: detect pulses next cycle, detectIndex = k, state -> DONE.
  - Otherwise, if k >= maxSamples: timeout pulses, state -> DONE. Detection wins over timeout in the same compare cycle.
  - maxSamples = 0 gives a timeout on the first compare cycle.
- adcValid may be high in a compare cycle. Back-to-back samples are supported: that sample is enabled and counted before the DONE transition. detectIndex still latches the pre-increment k.
- In DONE and IDLE, sumEnable stays 0, so the datapath freezes its output. Compares pending at abort are discarded.
- start while busy is ignored. detect/timeout never assert in the same cycle. busy, windowFull and done are mutually consistent with the state.

Test Plan:
1. RST_N low 2 cycles mid-RUN with adcValid=1 -> next cycle: all outputs 0, sumEnable 0, state IDLE. Then start -> busy=1 the following cycle.
2. start, adcValid every cycle, energyIn=500, threshold=1000, maxSamples=300:
   - windowFull rises after enable 261.
   - Single timeout pulse in the compare cycle after enable 300; detect stays 0.
   - done=1, busy=0, sumEnable 0 thereafter.
3. threshold=1000, energyIn=2000 in the compare cycles following enables 270..273, otherwise 0:
   - detect pulses once and detectIndex=273; timeout stays 0.
4. energyIn>threshold after enables 265..267, equal to threshold (1000) after enable 268, then above again at 269..271:
   - No detect through 271; detect at 272 if it stays above.
5. energyIn=2000 from enable 250 onward -> FILL compares are ignored; detectIndex=264.
   - Same stimulus with maxSamples=264 -> detect (not timeout) at 264.
6. Abort at enable 280 in RUN -> sumEnable 0 in that cycle, IDLE next, no detect/timeout.
   - start+abort in the same cycle -> stays IDLE.
   - start during FILL -> ignored; sampleCount not cleared.

Source files
------------

// File: rtl/echo_energy_ctrl_if.sv
// Bus between the echo energy controller and its host/datapath.
// The host side drives control and energy; the controller side returns enables and status.
interface echo_energy_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             adcValid;
  logic [23:0]      energyIn;
  logic [23:0]      threshold;
  logic [CNT_W-1:0] maxSamples;
  logic             sumEnable;
  logic             busy;
  logic             windowFull;
  logic             detect;
  logic             timeout;
  logic             done;
  logic [CNT_W-1:0] detectIndex;

  modport master (
    output start, abort, adcValid, energyIn, threshold, maxSamples,
    input  sumEnable, busy, windowFull, detect, timeout, done, detectIndex
  );

  modport slave (
    input  start, abort, adcValid, energyIn, threshold, maxSamples,
    output sumEnable, busy, windowFull, detect, timeout, done, detectIndex
  );
endinterface

// File: rtl/echo_energy_ctrl.sv
// Capture sequencer for the sliding-window sum-of-squares echo detector:
// flushes the window after arming, then confirms energy over threshold or times out.
module echo_energy_ctrl #(
  parameter int WINDOW  = 260,
  parameter int CONFIRM = 4,
  parameter int CNT_W   = 16
) (
  input logic               SYS_CLK,
  input logic               RST_N,
  echo_energy_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_e;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(WINDOW + 1);
  localparam logic [CNT_W-1:0] COUNT_MAX  = '1;
  localparam logic [3:0]       CONFIRM_N  = 4'(CONFIRM);

  state_e           state;
  logic [CNT_W-1:0] sample_count;
  logic [3:0]       run_cnt;
  logic             cmp_pending;

  logic active, cmp_now, k_full, above, hit, expire;
  logic go_fill, go_done, go_run;

  // The datapath has no reset of its own, so its enable must drop combinationally
  // with reset and abort to keep it from consuming a sample in those cycles.
  assign active        = (state == FILL) || (state == RUN);
  assign bus.sumEnable = bus.adcValid & active & ~bus.abort & RST_N;

  // Compare cycle: energyIn now holds the value registered at the previous enable.
  assign cmp_now = cmp_pending & active;
  assign k_full  = sample_count >= FULL_COUNT;
  assign above   = bus.energyIn > bus.threshold;
  assign hit     = cmp_now & k_full & above & ((run_cnt + 4'd1) >= CONFIRM_N);
  assign expire  = cmp_now & ~hit & (sample_count >= bus.maxSamples);

  assign go_fill = ~bus.abort & bus.start & ~active;
  assign go_done = ~bus.abort & (hit | expire);
  assign go_run  = ~bus.abort & ~go_done & (state == FILL) & bus.sumEnable
                 & ((sample_count + 1'b1) == FULL_COUNT);

  // NOTE: every register here is assigned with <= so all branches see the pre-edge values.
  always_ff @(posedge SYS_CLK) begin
    if (!RST_N) begin
      state           <= IDLE;
      sample_count    <= '0;
      run_cnt         <= '0;
      cmp_pending     <= 1'b0;
      bus.busy        <= 1'b0;
      bus.windowFull  <= 1'b0;
      bus.done        <= 1'b0;
      bus.detect      <= 1'b0;
      bus.timeout     <= 1'b0;
      bus.detectIndex <= '0;
    end else begin
      bus.detect  <= hit & ~bus.abort;
      bus.timeout <= expire & ~bus.abort;

      if (bus.abort) begin
        state          <= IDLE;
        cmp_pending    <= 1'b0;
        run_cnt        <= '0;
        bus.busy       <= 1'b0;
        bus.windowFull <= 1'b0;
        bus.done       <= 1'b0;
      end else if (go_fill) begin
        state           <= FILL;
        sample_count    <= '0;
        run_cnt         <= '0;
        cmp_pending     <= 1'b0;
        bus.detectIndex <= '0;
        bus.busy        <= 1'b1;
        bus.windowFull  <= 1'b0;
        bus.done        <= 1'b0;
      end else if (active) begin
        if (cmp_now) begin
          run_cnt <= (k_full && above) ? run_cnt + 4'd1 : 4'd0;
        end
        if (bus.sumEnable && sample_count != COUNT_MAX) begin
          sample_count <= sample_count + 1'b1;
        end
        // A sample arriving in the final compare cycle is counted but never compared.
        cmp_pending <= bus.sumEnable & ~go_done;

        if (go_done) begin
          state          <= DONE;
          bus.busy       <= 1'b0;
          bus.windowFull <= 1'b0;
          bus.done       <= 1'b1;
          if (hit) begin
            bus.detectIndex <= sample_count;
          end
        end else if (go_run) begin
          state          <= RUN;
          bus.windowFull <= 1'b1;
        end
      end
    end
  end

endmodule
